// File: rtl/dmem_access_ctrl.sv
// MEM-stage load/store controller: frames one BRAM access per request,
// builds store lanes, extracts and extends load data, stalls the pipe.
module dmem_access_ctrl #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        misalign,
    output logic        timeout_err,
    output logic        mem_ce,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_byte_sel,
    input  logic [31:0] mem_rd_data,
    input  logic        mem_ready
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RELEASE
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] cnt;
    logic [1:0]    size_q;
    logic          uns_q;
    logic          req_valid_q;

    logic          accept;
    logic          done_ok;
    logic          done_to;
    logic [3:0]    bsel_nx;
    logic [31:0]   wdata_nx;
    logic [4:0]    shamt;
    logic [31:0]   shifted;
    logic [31:0]   load_data;

    always_comb begin
        misalign = 1'b0;
        if (req_valid) begin
            unique case (req_size)
                2'b00:   misalign = 1'b0;
                2'b01:   misalign = req_addr[0];
                2'b10:   misalign = |req_addr[1:0];
                default: misalign = 1'b1;
            endcase
        end
    end

    assign accept     = (state == IDLE) & req_valid & ~misalign;
    assign stall      = req_valid & ~misalign & (state != RELEASE);
    assign resp_valid = (state == RELEASE);
    assign done_ok    = (state == ACCESS) & mem_ready;
    assign done_to    = (state == ACCESS) & ~mem_ready
                      & (cnt == CW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (accept) state_nx = ACCESS;
            ACCESS:  if (done_ok | done_to) state_nx = RELEASE;
            RELEASE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bsel_nx  = 4'b1111;
        wdata_nx = req_wdata;
        unique case (req_size)
            2'b00: begin
                bsel_nx  = 4'b0001 << req_addr[1:0];
                wdata_nx = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                bsel_nx  = req_addr[1] ? 4'b1100 : 4'b0011;
                wdata_nx = {2{req_wdata[15:0]}};
            end
            default: begin
                bsel_nx  = 4'b1111;
                wdata_nx = req_wdata;
            end
        endcase
    end

    assign shamt   = {mem_addr[1:0], 3'b000};
    assign shifted = mem_rd_data >> shamt;

    always_comb begin
        load_data = shifted;
        unique case (size_q)
            2'b00: load_data = uns_q ? {24'd0, shifted[7:0]}
                                     : {{24{shifted[7]}}, shifted[7:0]};
            2'b01: load_data = uns_q ? {16'd0, shifted[15:0]}
                                     : {{16{shifted[15]}}, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt          <= '0;
            size_q       <= 2'b00;
            uns_q        <= 1'b0;
            req_valid_q  <= 1'b0;
            resp_rdata   <= 32'd0;
            timeout_err  <= 1'b0;
            mem_ce       <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= 32'd0;
            mem_wdata    <= 32'd0;
            mem_byte_sel <= 4'b0000;
        end else begin
            req_valid_q <= req_valid;
            // the pipeline must hold its request for the whole access
            if (state == ACCESS) begin
                assert (req_valid == req_valid_q);
            end
            if (state == RELEASE) begin
                timeout_err <= 1'b0;
            end
            if (accept) begin
                cnt          <= '0;
                size_q       <= req_size;
                uns_q        <= req_unsigned;
                mem_ce       <= 1'b1;
                mem_we       <= req_we;
                mem_addr     <= req_addr;
                mem_wdata    <= wdata_nx;
                mem_byte_sel <= req_we ? bsel_nx : 4'b0000;
            end else if (done_ok | done_to) begin
                resp_rdata   <= (done_ok & ~mem_we) ? load_data : 32'd0;
                timeout_err  <= done_to;
                mem_ce       <= 1'b0;
                mem_we       <= 1'b0;
                mem_byte_sel <= 4'b0000;
            end else if (state == ACCESS) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule
